// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial_tx frame transmitter: FSM state
// encodings, line levels and the counter-width helper.
package serial_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Width of a counter that must hold 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/serial_tx_tick.sv
// bit_tick_gen: divides clk by CLK_DIV and pulses tick for one cycle on the
// last count of every bit period. clr restarts the period from zero.
module bit_tick_gen
    import serial_tx_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int CW = cnt_w(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    // Next count: clear on request, wrap after the last cycle of a bit.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// serial_tx: accepts a DATA_W-bit word on a valid/ready handshake and sends
// it as start(0), data LSB first, [parity], stop(1), each bit CLK_DIV cycles.
// Optional feature macro: SERIAL_TX_PARITY_EN inserts an even-parity bit.
// All outputs are driven from flops computed from the next state.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              busy
);

    localparam int IW = cnt_w(DATA_W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              tx_out_q, tx_out_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              tick_s;
    logic              tick_clr_s;
    logic              hs_s;

`ifdef SERIAL_TX_PARITY_EN
    logic par_q, par_d;

    function automatic logic even_par(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction
`endif

    // Bit timing restarts from zero whenever the line is idle.
    assign tick_clr_s = (state_q == ST_IDLE);
    assign hs_s       = tx_valid && tx_ready_q;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr_s),
        .tick  (tick_s)
    );

    // Frame sequencing: load on handshake, advance one bit per tick.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hs_s) begin
                    state_d = ST_START;
                    shreg_d = tx_data;
                    idx_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = even_par(tx_data);
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    shreg_d = shreg_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        tx_out_d   = LINE_IDLE;
        tx_ready_d = 1'b0;
        busy_d     = 1'b1;
        case (state_d)
            ST_IDLE: begin
                tx_out_d   = LINE_IDLE;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            ST_START: tx_out_d = START_BIT;
            ST_DATA:  tx_out_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            ST_PARITY: tx_out_d = par_d;
`endif
            ST_STOP:  tx_out_d = STOP_BIT;
            default: begin
                tx_out_d   = LINE_IDLE;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            idx_q      <= '0;
            tx_out_q   <= LINE_IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            idx_q      <= idx_d;
            tx_out_q   <= tx_out_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign tx_out   = tx_out_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx. Expected line bits are pushed to a
// scoreboard queue at each handshake and popped one per cycle.
module tb_serial_tx;

    localparam int DATA_W = 8;
`ifdef SERIAL_TX_PARITY_EN
    localparam int CLK_DIV = 1;
    localparam int NBITS   = DATA_W + 3;
`else
    localparam int CLK_DIV = 4;
    localparam int NBITS   = DATA_W + 2;
`endif
    localparam int F = NBITS * CLK_DIV;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic              tx_out;
    logic              busy;

    int runs  = 0;
    int fails = 0;
    int cyc   = 0;
    logic exp_q[$];
    int   hs_cycles[$];

    serial_tx #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_out   (tx_out),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Cycle counter and log of the edges at which a handshake took place.
    always @(posedge clk) begin
        if (reset === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            hs_cycles.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    // Expected line contents for one frame carrying d.
    task automatic push_frame(input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] v;
        logic p;
        v = d;
        p = 1'b0;
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b0);
        for (int b = 0; b < DATA_W; b++) begin
            p = p ^ v[b];
            for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(v[b]);
        end
`ifdef SERIAL_TX_PARITY_EN
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(p);
`endif
        for (int c = 0; c < CLK_DIV; c++) exp_q.push_back(1'b1);
    endtask

    // Check the idle-line outputs in the current cycle.
    task automatic check_idle(input string name);
        runs++;
        if (tx_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s: tx_out=%b tx_ready=%b busy=%b, required 1/1/0", name, tx_out, tx_ready, busy);
        end
    endtask

    // Send one word and check the whole frame. Called just after a negedge.
    // mode 0: drop valid after handshake; 1: keep valid with nxt; 2: scramble tx_data.
    task automatic send_frame(input logic [DATA_W-1:0] d, input int mode, input logic [DATA_W-1:0] nxt);
        int n;
        logic e;
        tx_data  = d;
        tx_valid = 1'b1;
        n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        runs++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL hs_timeout: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
            tx_valid = 1'b0;
            return;
        end
        push_frame(d);
        @(negedge clk);
        for (int c = 0; c < F; c++) begin
            case (mode)
                1: tx_data = nxt;
                2: begin tx_valid = 1'b0; tx_data = DATA_W'($urandom); end
                default: tx_valid = 1'b0;
            endcase
            e = exp_q.pop_front();
            runs++;
            if (tx_out !== e || busy !== 1'b1 || tx_ready !== 1'b0) begin
                fails++;
                $display("FAIL frame_%h bit-cycle %0d: tx_out=%b busy=%b tx_ready=%b, required %b/1/0",
                         d, c, tx_out, busy, tx_ready, e);
            end
            @(negedge clk);
        end
        check_idle("frame_end");
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("reset_hold");
        end
        tx_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_idle("after_reset");
        runs++;
        if (hs_cycles.size() != 0) begin
            fails++;
            $display("FAIL reset_no_frame: %0d handshakes seen, required 0", hs_cycles.size());
        end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 0, 8'h00);
        send_frame(8'h5A, 0, 8'h00);
    endtask

    task automatic test_back_to_back();
        hs_cycles.delete();
        send_frame(8'h00, 1, 8'hFF);
        send_frame(8'hFF, 0, 8'h00);
        runs++;
        if (hs_cycles.size() != 2) begin
            fails++;
            $display("FAIL b2b_count: %0d handshakes, required 2", hs_cycles.size());
        end else if (hs_cycles[1] - hs_cycles[0] != F + 1) begin
            fails++;
            $display("FAIL b2b_spacing: %0d cycles, required %0d", hs_cycles[1] - hs_cycles[0], F + 1);
        end
    endtask

    task automatic test_data_stable();
        send_frame(8'h3C, 2, 8'h00);
    endtask

    task automatic test_mid_reset();
        logic e;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        runs++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL midrst_ready: tx_ready=%b, required 1", tx_ready);
        end
        push_frame(8'hA5);
        @(negedge clk);
        tx_valid = 1'b0;
        for (int c = 0; c < 15 && c < F; c++) begin
            e = exp_q.pop_front();
            runs++;
            if (tx_out !== e || busy !== 1'b1) begin
                fails++;
                $display("FAIL midrst_frame cycle %0d: tx_out=%b busy=%b, required %b/1", c, tx_out, busy, e);
            end
            if (c < 14 && c < F - 1) @(negedge clk);
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle("midrst_abort");
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_idle("midrst_idle");
        send_frame(8'h81, 0, 8'h00);
    endtask

`ifdef SERIAL_TX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 0, 8'h00);
        send_frame(8'hA5, 0, 8'h00);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_data_stable();
        test_mid_reset();
`ifdef SERIAL_TX_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", runs, fails);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parallel-in, serial-out frame transmitter. It accepts a DATA_W-bit word over a valid/ready handshake and shifts it out on a single line as an asynchronous-serial frame: start bit 0, data LSB first, optional parity, stop bit 1. It is the sending end of the single-bit serial link whose receive side is built from synchronous-reset flip-flops in the same library. Each bit is held for CLK_DIV clock cycles.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- CLK_DIV, 4, clock cycles per serial bit (≥1)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low; clock clk
- tx_data  input  DATA_W  word to send; sampled only on handshake
- tx_valid  input  1  tx_data is valid
- tx_ready  output  1  block can accept a word (registered)
- tx_out  output  1  serial line, idles high (registered)
- busy  output  1  frame in progress (registered)

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- IDLE: tx_ready=1, busy=0, tx_out=1. Handshake is tx_valid&&tx_ready at a rising edge. On handshake: tx_data is loaded into the shift register, bit index is cleared, the tick counter is cleared, the FSM goes to START, and tx_ready drops to 0.
- START: tx_out=0 for CLK_DIV cycles, then DATA.
- DATA: tx_out = shreg[0]. Every CLK_DIV cycles the register shifts right and the bit index increments. After bit DATA_W-1 completes, the FSM goes to PARITY if enabled, else STOP.
- STOP: tx_out=1 for CLK_DIV cycles, then IDLE with tx_ready=1.
- The tick counter counts 0..CLK_DIV-1 and wraps. Its width is max(1, clog2(CLK_DIV)). With CLK_DIV=1, every cycle is a bit boundary.
- Bit index width is max(1, clog2(DATA_W+1)).
- tx_data changes after the handshake have no effect on the frame in flight.
- tx_valid while not ready is ignored. No buffering; the source must hold tx_valid until tx_ready.
- Reset (low at an edge) takes priority over everything: state goes to IDLE, tx_out=1, tx_ready=1, busy=0, and the shift register, counter and index clear. A frame in flight is aborted and truncated with no stop-bit completion.
- A handshake in the same cycle as reset is discarded.

## Timing
- Reset values: tx_out=1, tx_ready=1, busy=0.
- Handshake at edge k: tx_out=0 and busy=1 from edge k (visible in cycle k+1). The start bit occupies cycles k+1..k+CLK_DIV.
- Data bit i occupies cycles k+1+(i+1)*CLK_DIV .. k+(i+2)*CLK_DIV.
- Frame length F = (DATA_W+2)*CLK_DIV cycles, or (DATA_W+3)*CLK_DIV with parity.
- tx_ready=1 and busy=0 are visible in cycle k+F+1, so the earliest next handshake is at edge k+F+1.
- Minimum accept-to-accept spacing is F+1 cycles, with one idle-high cycle between frames.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state is inserted after DATA.
  - tx_out = even parity (XOR of all DATA_W bits, computed at handshake and stored) for CLK_DIV cycles.
  - F grows by CLK_DIV.
- Not defined: the PARITY state, the parity flop and its logic are absent. DATA goes directly to STOP.

## Structure
- Shared package serial_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - LINE_IDLE=1'b1, START_BIT=1'b0, STOP_BIT=1'b1
  - width helper function for counters
- One sub-module, bit_tick_gen:
  - CLK_DIV counter with a sync clear input
  - emits a one-cycle tick on count CLK_DIV-1
  - uses the same reset convention.
- The top level holds the FSM, shift register, index and output flops.

## Test plan
- Reset held low 3 cycles with tx_valid=1 -> tx_out=1, tx_ready=1, busy=0 throughout, and no frame starts.
- DATA_W=8, CLK_DIV=4, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles (40 cycles total). tx_ready returns high at cycle 41 after the handshake.
- Back-to-back 0x00 then 0xFF with tx_valid held high -> second handshake exactly 41 cycles after the first. Frames read 0,00000000,1 and 0,11111111,1 with one idle-high cycle between them.
- tx_data changed every cycle after the 0x3C handshake -> line still carries 0x3C (0,0,0,1,1,1,1,0,0,1).
- Reset driven low in cycle 15 of the 0xA5 frame -> next cycle tx_out=1, tx_ready=1, busy=0. A new 0x81 sent afterwards produces a clean full frame.
- SERIAL_TX_PARITY_EN, CLK_DIV=1, send 0x07 -> sequence 0,1,1,1,0,0,0,0,0,1,1 (parity 1). Sending 0xA5 yields parity 0 and F=11.
